// File: rtl/alg_apb_timeout_stage_if.sv
// APB4 bus bundle shared by the upstream and downstream sides of the timeout stage.
// The master modport drives the request; the slave modport drives the response.
interface alg_apb_timeout_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic [2:0]            pprot;
    logic                  pready;
    logic [DATA_W-1:0]     prdata;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/alg_apb_timeout_stage.sv
// Single-clock APB4 register slice with a wait-state watchdog that aborts hung
// downstream accesses with PSLVERR plus a poison read value.
module alg_apb_timeout_stage #(
    parameter int          ADDR_W         = 32,
    parameter int          DATA_W         = 32,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] POISON_DATA    = 32'hDEAD_BEEF,
    parameter int          CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alg_apb_timeout_stage_if.slave  s_apb,
    alg_apb_timeout_stage_if.master m_apb,
    output logic                 timeout_o,
    output logic [CNT_W-1:0]     timeout_cnt,
    output logic                 busy_o
);

    localparam bit WD_EN  = (TIMEOUT_CYCLES > 32'sd0);
    localparam int WAIT_W = WD_EN ? $clog2(TIMEOUT_CYCLES + 32'sd1) : 32'sd1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'(WD_EN ? TIMEOUT_CYCLES - 32'sd1 : TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(32'd1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [DATA_W-1:0] POISON_W  = DATA_W'(POISON_DATA);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state_r, state_nxt_s;
    logic                  m_psel_r, m_psel_nxt_s;
    logic                  m_penable_r, m_penable_nxt_s;
    logic                  m_pwrite_r, m_pwrite_nxt_s;
    logic [ADDR_W-1:0]     m_paddr_r, m_paddr_nxt_s;
    logic [DATA_W-1:0]     m_pwdata_r, m_pwdata_nxt_s;
    logic [DATA_W/8-1:0]   m_pstrb_r, m_pstrb_nxt_s;
    logic [2:0]            m_pprot_r, m_pprot_nxt_s;
    logic                  s_pready_r, s_pready_nxt_s;
    logic [DATA_W-1:0]     s_prdata_r, s_prdata_nxt_s;
    logic                  s_pslverr_r, s_pslverr_nxt_s;
    logic                  timeout_r, timeout_nxt_s;
    logic [CNT_W-1:0]      timeout_cnt_r, timeout_cnt_nxt_s;
    logic                  busy_r, busy_nxt_s;
    logic [WAIT_W-1:0]     wait_cnt_r, wait_cnt_nxt_s;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-output logic; every register holds unless a state acts on it
    always_comb begin
        state_nxt_s       = state_r;
        m_psel_nxt_s      = m_psel_r;
        m_penable_nxt_s   = m_penable_r;
        m_pwrite_nxt_s    = m_pwrite_r;
        m_paddr_nxt_s     = m_paddr_r;
        m_pwdata_nxt_s    = m_pwdata_r;
        m_pstrb_nxt_s     = m_pstrb_r;
        m_pprot_nxt_s     = m_pprot_r;
        s_pready_nxt_s    = 1'b0;
        s_prdata_nxt_s    = s_prdata_r;
        s_pslverr_nxt_s   = s_pslverr_r;
        timeout_nxt_s     = 1'b0;
        timeout_cnt_nxt_s = timeout_cnt_r;
        wait_cnt_nxt_s    = wait_cnt_r;
        case (state_r)
            IDLE: begin
                if (s_apb.psel && !s_apb.penable) begin
                    m_psel_nxt_s    = 1'b1;
                    m_penable_nxt_s = 1'b0;
                    m_pwrite_nxt_s  = s_apb.pwrite;
                    m_paddr_nxt_s   = s_apb.paddr;
                    m_pwdata_nxt_s  = s_apb.pwdata;
                    m_pstrb_nxt_s   = s_apb.pstrb;
                    m_pprot_nxt_s   = s_apb.pprot;
                    state_nxt_s     = SETUP;
                end else begin
                    state_nxt_s     = IDLE;
                end
            end
            SETUP: begin
                m_penable_nxt_s = 1'b1;
                wait_cnt_nxt_s  = {WAIT_W{1'b0}};
                state_nxt_s     = ACCESS;
            end
            ACCESS: begin
                // A ready completer always wins over an abort in the same cycle
                if (m_apb.pready) begin
                    s_prdata_nxt_s  = m_apb.prdata;
                    s_pslverr_nxt_s = m_apb.pslverr;
                    m_psel_nxt_s    = 1'b0;
                    m_penable_nxt_s = 1'b0;
                    s_pready_nxt_s  = 1'b1;
                    state_nxt_s     = RESP;
                end else if (WD_EN && (wait_cnt_r == WAIT_LAST)) begin
                    s_prdata_nxt_s  = POISON_W;
                    s_pslverr_nxt_s = 1'b1;
                    m_psel_nxt_s    = 1'b0;
                    m_penable_nxt_s = 1'b0;
                    s_pready_nxt_s  = 1'b1;
                    timeout_nxt_s   = 1'b1;
                    if (timeout_cnt_r != CNT_MAX) begin
                        timeout_cnt_nxt_s = timeout_cnt_r + CNT_ONE;
                    end else begin
                        timeout_cnt_nxt_s = timeout_cnt_r;
                    end
                    state_nxt_s     = RESP;
                end else if (WD_EN) begin
                    wait_cnt_nxt_s  = wait_cnt_r + WAIT_ONE;
                end else begin
                    wait_cnt_nxt_s  = wait_cnt_r;
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s     = IDLE;
                m_psel_nxt_s    = 1'b0;
                m_penable_nxt_s = 1'b0;
            end
        endcase
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // Output and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_psel_r      <= 1'b0;
            m_penable_r   <= 1'b0;
            m_pwrite_r    <= 1'b0;
            m_paddr_r     <= {ADDR_W{1'b0}};
            m_pwdata_r    <= {DATA_W{1'b0}};
            m_pstrb_r     <= {(DATA_W/8){1'b0}};
            m_pprot_r     <= 3'b000;
            s_pready_r    <= 1'b0;
            s_prdata_r    <= {DATA_W{1'b0}};
            s_pslverr_r   <= 1'b0;
            timeout_r     <= 1'b0;
            timeout_cnt_r <= {CNT_W{1'b0}};
            busy_r        <= 1'b0;
            wait_cnt_r    <= {WAIT_W{1'b0}};
        end else begin
            m_psel_r      <= m_psel_nxt_s;
            m_penable_r   <= m_penable_nxt_s;
            m_pwrite_r    <= m_pwrite_nxt_s;
            m_paddr_r     <= m_paddr_nxt_s;
            m_pwdata_r    <= m_pwdata_nxt_s;
            m_pstrb_r     <= m_pstrb_nxt_s;
            m_pprot_r     <= m_pprot_nxt_s;
            s_pready_r    <= s_pready_nxt_s;
            s_prdata_r    <= s_prdata_nxt_s;
            s_pslverr_r   <= s_pslverr_nxt_s;
            timeout_r     <= timeout_nxt_s;
            timeout_cnt_r <= timeout_cnt_nxt_s;
            busy_r        <= busy_nxt_s;
            wait_cnt_r    <= wait_cnt_nxt_s;
        end
    end

    assign m_apb.psel    = m_psel_r;
    assign m_apb.penable = m_penable_r;
    assign m_apb.pwrite  = m_pwrite_r;
    assign m_apb.paddr   = m_paddr_r;
    assign m_apb.pwdata  = m_pwdata_r;
    assign m_apb.pstrb   = m_pstrb_r;
    assign m_apb.pprot   = m_pprot_r;
    assign s_apb.pready  = s_pready_r;
    assign s_apb.prdata  = s_prdata_r;
    assign s_apb.pslverr = s_pslverr_r;
    assign timeout_o     = timeout_r;
    assign timeout_cnt   = timeout_cnt_r;
    assign busy_o        = busy_r;

endmodule

// File: tb/tb_alg_apb_timeout_stage.sv
// Directed bench for alg_apb_timeout_stage: DUT 0 uses the default watchdog,
// DUT 1 uses TIMEOUT_CYCLES=4 with a 2-bit saturating event counter.
module tb_alg_apb_timeout_stage;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    logic        psel[2], penable[2], pwrite[2];
    logic [31:0] paddr[2], pwdata[2];
    logic [3:0]  pstrb[2];
    logic [2:0]  pprot[2];
    logic        mready[2], merr[2];
    logic [31:0] mrdata[2];

    logic        spready[2], sslverr[2], mpsel[2], mpen[2], mpwrite[2], tmo[2], busy[2];
    logic [31:0] sprdata[2], mpaddr[2], mpwdata[2];
    logic [3:0]  mpstrb[2];
    logic [2:0]  mpprot[2];
    logic [7:0]  tcnt[2];
    logic [7:0]  cnt_a;
    logic [1:0]  cnt_b;

    alg_apb_timeout_stage_if #(.ADDR_W(32), .DATA_W(32)) sa ();
    alg_apb_timeout_stage_if #(.ADDR_W(32), .DATA_W(32)) ma ();
    alg_apb_timeout_stage_if #(.ADDR_W(32), .DATA_W(32)) sb ();
    alg_apb_timeout_stage_if #(.ADDR_W(32), .DATA_W(32)) mb ();

    alg_apb_timeout_stage #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(256), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .s_apb(sa), .m_apb(ma),
        .timeout_o(tmo[0]), .timeout_cnt(cnt_a), .busy_o(busy[0])
    );

    alg_apb_timeout_stage #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .s_apb(sb), .m_apb(mb),
        .timeout_o(tmo[1]), .timeout_cnt(cnt_b), .busy_o(busy[1])
    );

    assign sa.psel = psel[0];  assign sa.penable = penable[0]; assign sa.pwrite = pwrite[0];
    assign sa.paddr = paddr[0]; assign sa.pwdata = pwdata[0]; assign sa.pstrb = pstrb[0];
    assign sa.pprot = pprot[0];
    assign ma.pready = mready[0]; assign ma.prdata = mrdata[0]; assign ma.pslverr = merr[0];
    assign sb.psel = psel[1];  assign sb.penable = penable[1]; assign sb.pwrite = pwrite[1];
    assign sb.paddr = paddr[1]; assign sb.pwdata = pwdata[1]; assign sb.pstrb = pstrb[1];
    assign sb.pprot = pprot[1];
    assign mb.pready = mready[1]; assign mb.prdata = mrdata[1]; assign mb.pslverr = merr[1];

    assign spready[0] = sa.pready; assign sprdata[0] = sa.prdata; assign sslverr[0] = sa.pslverr;
    assign mpsel[0] = ma.psel; assign mpen[0] = ma.penable; assign mpwrite[0] = ma.pwrite;
    assign mpaddr[0] = ma.paddr; assign mpwdata[0] = ma.pwdata; assign mpstrb[0] = ma.pstrb;
    assign mpprot[0] = ma.pprot;
    assign spready[1] = sb.pready; assign sprdata[1] = sb.prdata; assign sslverr[1] = sb.pslverr;
    assign mpsel[1] = mb.psel; assign mpen[1] = mb.penable; assign mpwrite[1] = mb.pwrite;
    assign mpaddr[1] = mb.paddr; assign mpwdata[1] = mb.pwdata; assign mpstrb[1] = mb.pstrb;
    assign mpprot[1] = mb.pprot;
    assign tcnt[0] = cnt_a;
    assign tcnt[1] = {6'd0, cnt_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input int d);
        chk($sformatf("rst_m_psel%0d", d), 32'(mpsel[d]), 32'd0);
        chk($sformatf("rst_m_penable%0d", d), 32'(mpen[d]), 32'd0);
        chk($sformatf("rst_s_pready%0d", d), 32'(spready[d]), 32'd0);
        chk($sformatf("rst_s_prdata%0d", d), sprdata[d], 32'd0);
        chk($sformatf("rst_s_pslverr%0d", d), 32'(sslverr[d]), 32'd0);
        chk($sformatf("rst_m_paddr%0d", d), mpaddr[d], 32'd0);
        chk($sformatf("rst_timeout%0d", d), 32'(tmo[d]), 32'd0);
        chk($sformatf("rst_cnt%0d", d), 32'(tcnt[d]), 32'd0);
        chk($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
    endtask

    // One upstream transfer; n_acc is the number of downstream ACCESS cycles expected
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                        input int n_acc, input logic [31:0] rdata, input logic err,
                        input logic exp_tmo, input logic [7:0] exp_cnt);
        logic [31:0] exp_rd;
        exp_rd = exp_tmo ? 32'hDEAD_BEEF : rdata;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr;
        pwdata[d] = wdata; pstrb[d] = strb; pprot[d] = prot;
        mready[d] = 1'b0; mrdata[d] = 32'd0; merr[d] = 1'b0;
        tick();
        chk("c1_m_psel", 32'(mpsel[d]), 32'd1);
        chk("c1_m_penable", 32'(mpen[d]), 32'd0);
        chk("c1_busy", 32'(busy[d]), 32'd1);
        chk("c1_m_pwrite", 32'(mpwrite[d]), 32'(wr));
        chk("c1_m_paddr", mpaddr[d], addr);
        chk("c1_m_pwdata", mpwdata[d], wdata);
        chk("c1_m_pstrb", 32'(mpstrb[d]), 32'(strb));
        chk("c1_m_pprot", 32'(mpprot[d]), 32'(prot));
        penable[d] = 1'b1;
        tick();
        for (int k = 1; k <= n_acc; k++) begin
            chk($sformatf("acc%0d_m_psel", k), 32'(mpsel[d]), 32'd1);
            chk($sformatf("acc%0d_m_penable", k), 32'(mpen[d]), 32'd1);
            chk($sformatf("acc%0d_s_pready", k), 32'(spready[d]), 32'd0);
            if (!exp_tmo && k == n_acc) begin
                mready[d] = 1'b1; mrdata[d] = rdata; merr[d] = err;
            end
            tick();
        end
        mready[d] = 1'b0;
        chk("resp_s_pready", 32'(spready[d]), 32'd1);
        chk("resp_m_psel", 32'(mpsel[d]), 32'd0);
        chk("resp_m_penable", 32'(mpen[d]), 32'd0);
        chk("resp_s_prdata", sprdata[d], exp_rd);
        chk("resp_s_pslverr", 32'(sslverr[d]), 32'(exp_tmo | err));
        chk("resp_timeout_o", 32'(tmo[d]), 32'(exp_tmo));
        chk("resp_timeout_cnt", 32'(tcnt[d]), 32'(exp_cnt));
        tick();
        psel[d] = 1'b0; penable[d] = 1'b0;
        chk("post_s_pready", 32'(spready[d]), 32'd0);
        chk("post_timeout_o", 32'(tmo[d]), 32'd0);
        chk("post_busy", 32'(busy[d]), 32'd0);
        chk("post_s_prdata_hold", sprdata[d], exp_rd);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = 32'd0;
            pwdata[d] = 32'd0; pstrb[d] = 4'd0; pprot[d] = 3'd0;
            mready[d] = 1'b0; mrdata[d] = 32'd0; merr[d] = 1'b0;
        end
        rst = 1'b1;
        tick();
        tick();
        chk_idle_zero(0);
        chk_idle_zero(1);
        rst = 1'b0;
        tick();

        // Write, completer ready immediately: s_pready in cycle 3
        xfer(0, 1'b1, 32'h40, 32'h1234_5678, 4'hF, 3'b010, 1, 32'h0, 1'b0, 1'b0, 8'd0);
        // Read with 3 wait states returning an error
        xfer(0, 1'b0, 32'h80, 32'h0, 4'h0, 3'b000, 4, 32'hCAFE_F00D, 1'b1, 1'b0, 8'd0);
        // Watchdog abort after 4 ACCESS cycles
        xfer(1, 1'b0, 32'h100, 32'h0, 4'h0, 3'b001, 4, 32'h0, 1'b0, 1'b1, 8'd1);
        // Ready in the 4th ACCESS cycle beats the abort
        xfer(1, 1'b0, 32'h104, 32'h0, 4'h0, 3'b000, 4, 32'h11, 1'b0, 1'b0, 8'd1);

        // Saturation of the 2-bit counter from a clean reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        xfer(1, 1'b0, 32'h200, 32'h0, 4'h0, 3'b000, 4, 32'h0, 1'b0, 1'b1, 8'd1);
        xfer(1, 1'b1, 32'h204, 32'h55, 4'h3, 3'b000, 4, 32'h0, 1'b0, 1'b1, 8'd2);
        xfer(1, 1'b0, 32'h208, 32'h0, 4'h0, 3'b000, 4, 32'h0, 1'b0, 1'b1, 8'd3);
        xfer(1, 1'b0, 32'h20C, 32'h0, 4'h0, 3'b000, 4, 32'h0, 1'b0, 1'b1, 8'd3);
        xfer(1, 1'b0, 32'h210, 32'h0, 4'h0, 3'b000, 4, 32'h0, 1'b0, 1'b1, 8'd3);

        // Asynchronous reset while DUT 0 sits in ACCESS
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 32'h300;
        tick();
        penable[0] = 1'b1;
        tick();
        chk("pre_rst_m_penable", 32'(mpen[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_idle_zero(0);
        #2;
        psel[0] = 1'b0; penable[0] = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("after_rst_busy", 32'(busy[0]), 32'd0);
        xfer(0, 1'b0, 32'h304, 32'h0, 4'h0, 3'b100, 2, 32'hA5A5_0001, 1'b0, 1'b0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alg_apb_timeout_stage.md
Name: alg_apb_timeout_stage

Overview:
- Single-clock APB4 register slice for the DCD Allegro testbench fabric. It is the parametrised successor to the dual-clock toggle-handshake APB stage.
- It sits between an upstream APB requester (s_*) and a downstream APB completer (m_*) in the same clock domain.
- Address and data widths are parametrised, and PSTRB/PPROT are forwarded.
- A programmable wait-state watchdog aborts hung downstream accesses with PSLVERR and a poison read value, and counts the events.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; multiple of 8
TIMEOUT_CYCLES, 256, max downstream ACCESS-phase cycles before abort; 0 disables watchdog
POISON_DATA, 32'hDEAD_BEEF, s_prdata returned on timeout (zero-extended/truncated to DATA_W)
CNT_W, 8, width of saturating timeout event counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_psel  in  1  upstream select
s_penable  in  1  upstream enable
s_pwrite  in  1  upstream write
s_paddr  in  ADDR_W  upstream address
s_pwdata  in  DATA_W  upstream write data
s_pstrb  in  DATA_W/8  upstream byte strobes
s_pprot  in  3  upstream protection
s_pready  out  1  upstream ready
s_prdata  out  DATA_W  upstream read data
s_pslverr  out  1  upstream error
m_psel  out  1  downstream select
m_penable  out  1  downstream enable
m_pwrite  out  1  downstream write
m_paddr  out  ADDR_W  downstream address
m_pwdata  out  DATA_W  downstream write data
m_pstrb  out  DATA_W/8  downstream strobes
m_pprot  out  3  downstream protection
m_pready  in  1  downstream ready
m_prdata  in  DATA_W  downstream read data
m_pslverr  in  1  downstream error
timeout_o  out  1  one-cycle pulse on watchdog abort
timeout_cnt  out  CNT_W  saturating count of aborts
busy_o  out  1  high whenever FSM != IDLE

Behaviour:
- Clocking/reset: single clock; reset is asynchronous and active-high. Reset drives every output to 0 and the FSM to IDLE. A reset mid-transfer drops m_psel/m_penable immediately, and no response is given.
- All outputs are registered; none is combinational from inputs.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - An upstream setup phase (s_psel & !s_penable) captures pwrite/paddr/pwdata/pstrb/pprot into the m_* registers and sets m_psel=1, m_penable=0. Next state is SETUP.
- SETUP: one cycle. Set m_penable=1, clear the wait counter. Next state is ACCESS.
- ACCESS:
  - If m_pready is high: capture m_prdata into s_prdata and m_pslverr into s_pslverr, drop m_psel/m_penable, go to RESP.
  - Otherwise, with TIMEOUT_CYCLES>0, the wait counter increments. When the counter reaches TIMEOUT_CYCLES-1 and m_pready is still low, the block aborts:
    - drop m_psel/m_penable;
    - s_prdata=POISON_DATA, s_pslverr=1;
    - pulse timeout_o;
    - increment timeout_cnt, saturating at all-ones;
    - go to RESP.
  - If m_pready is high in the abort cycle, the normal completion wins.
- RESP: s_pready=1 for exactly one cycle, then IDLE. s_pready is 0 in every other state.
- s_prdata and s_pslverr hold their values until the next completion. On a write, s_prdata is still loaded from m_prdata (the value is don't-care to the requester).
- Latency: an upstream setup in cycle 0 gives m_psel in cycle 1 and m_penable in cycle 2. If m_pready is high in cycle 2, s_pready is high in cycle 3. The minimum upstream transfer is 4 cycles; each downstream wait state adds 1 cycle.
- Watchdog boundary: with TIMEOUT_CYCLES=N, the downstream sees at most N ACCESS cycles. The abort is registered at the end of ACCESS cycle N.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1.
- Upstream protocol violation:
  - If s_psel drops mid-transfer, the downstream transfer still completes or times out, and RESP is still issued.
  - A new setup is accepted only in IDLE. Setup phases presented in SETUP, ACCESS or RESP are ignored.
- Back-to-back: a new setup can be accepted in the cycle after RESP (IDLE). There are no IDLE gap cycles beyond APB requirements.

Test Plan:
- Reset, then write addr 0x40, wdata 0x1234_5678, pstrb 0xF, pprot 3'b010, completer ready immediately -> m_* fields match the request; m_psel in cycle 1, m_penable in cycle 2; s_pready high in cycle 3 only; s_pslverr=0.
- Read addr 0x80, completer inserts 3 wait states, returns 0xCAFE_F00D with pslverr=1 -> s_pready in cycle 6, s_prdata=0xCAFE_F00D, s_pslverr=1, timeout_cnt=0.
- TIMEOUT_CYCLES=4, completer never ready -> m_psel/m_penable drop after 4 ACCESS cycles; s_prdata=0xDEAD_BEEF, s_pslverr=1; timeout_o pulses once; timeout_cnt=1.
- TIMEOUT_CYCLES=4, m_pready rises in ACCESS cycle 4 with rdata 0x11 -> normal completion, s_prdata=0x11, no timeout_o.
- CNT_W=2, 5 consecutive timeouts -> timeout_cnt goes 1,2,3,3,3.
- Assert rst during ACCESS -> all outputs 0 asynchronously, busy_o=0; the next request completes normally.
